// File: rtl/fetch_pc_gen.sv
// rtl/fetch_pc_gen.sv - fetch PC generator and next-PC selector feeding the BHT/BTB predictor
module fetch_pc_gen #(
  parameter logic [63:0] RESET_PC    = 64'h0000_0000_8000_0000,
  parameter int          FETCH_BYTES = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ifu_ready,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic [63:0] pc,
  output logic        pc_handshake,
  input  logic [32:0] bht_rd_data,
  input  logic [32:0] btb_rd_data,
  input  logic        btbtag_hit,
  output logic        pred_valid,
  output logic [63:0] pred_pc,
  output logic        pred_taken,
  output logic [63:0] pred_target,
  output logic [31:0] pred_taken_cnt
);

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  localparam logic [63:0] STEP       = 64'(FETCH_BYTES);
  localparam logic [63:0] ALIGN_MASK = ~(STEP - 64'd1);

  state_t      state_q;
  state_t      state_d;
  logic [63:0] pc_q;
  logic [63:0] pc_d;
  logic        f1_valid_q;
  logic [63:0] f1_pc_q;
  logic [31:0] taken_cnt_q;

  logic [3:0]  cnt_msb_idx;
  logic        cnt_taken;
  logic        taken_f1;
  logic [63:0] btb_target;
  logic        issue;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_BOOT;
    end else begin
      state_q <= state_d;
    end
  end

  // A redirect in any state costs exactly one dead cycle before issue resumes.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_BOOT:  state_d = redirect_valid ? ST_FLUSH : ST_RUN;
      ST_RUN:   state_d = redirect_valid ? ST_FLUSH : ST_RUN;
      ST_FLUSH: state_d = redirect_valid ? ST_FLUSH : ST_RUN;
      default:  state_d = ST_BOOT;
    endcase
  end

  // Predictor outputs belong to the block now in F1; pick its 2-bit counter MSB.
  assign cnt_msb_idx = {f1_pc_q[5:3], 1'b1};
  assign cnt_taken   = bht_rd_data[cnt_msb_idx];
  assign taken_f1    = f1_valid_q & btbtag_hit & bht_rd_data[32] & btb_rd_data[32] & cnt_taken;
  assign btb_target  = {32'b0, btb_rd_data[31:0]};

  assign issue = (state_q == ST_RUN) & ifu_ready & ~redirect_valid & ~taken_f1;

  always_comb begin
    pc_d = pc_q;
    if (redirect_valid) begin
      pc_d = redirect_pc;
    end else if (taken_f1) begin
      pc_d = btb_target;
    end else if (issue) begin
      pc_d = (pc_q & ALIGN_MASK) + STEP;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q        <= RESET_PC;
      f1_valid_q  <= 1'b0;
      f1_pc_q     <= 64'd0;
      taken_cnt_q <= 32'd0;
    end else begin
      pc_q       <= pc_d;
      f1_valid_q <= issue;
      if (issue) begin
        f1_pc_q <= pc_q;
      end
      if (pred_taken) begin
        taken_cnt_q <= taken_cnt_q + 32'd1;
      end
    end
  end

  assign pc             = pc_q;
  assign pc_handshake   = issue;
  assign pred_valid     = f1_valid_q & ~redirect_valid;
  assign pred_pc        = f1_pc_q;
  assign pred_taken     = taken_f1 & ~redirect_valid;
  assign pred_target    = pred_taken ? btb_target : 64'd0;
  assign pred_taken_cnt = taken_cnt_q;

endmodule
